// File: rtl/instr_mem.sv
// Writable instruction memory: images the boot program after reset, then serves
// registered fetches in RUN and accepts host writes while halted in LOAD.
module instr_mem #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 256
) (
    input  logic              clk,
    input  logic              rst,
    output logic              ready,
    input  logic              fetch_req,
    input  logic [ADDR_W-1:0] fetch_addr,
    output logic              fetch_valid,
    output logic [DATA_W-1:0] fetch_instr,
    output logic              fetch_err,
    input  logic              ld_start,
    input  logic              ld_we,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_data,
    input  logic              ld_done,
    output logic              ld_busy,
    output logic              ld_err
);

    localparam int              IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_C = ADDR_W'(DEPTH - 1);

    typedef enum logic [1:0] {S_INIT, S_RUN, S_LOAD} state_t;

    state_t            r_state;
    state_t            w_next;
    logic [ADDR_W-1:0] r_cnt;
    logic [DATA_W-1:0] r_mem [DEPTH];

    logic              r_ready;
    logic              r_busy;
    logic              r_fvalid;
    logic              r_ferr;
    logic              r_lderr;
    logic [DATA_W-1:0] r_finstr;

    logic              w_fetch_ok;
    logic              w_ld_ok;
    logic              w_fetch_go;
    logic              w_we;
    logic [IDX_W-1:0]  w_widx;
    logic [IDX_W-1:0]  w_ridx;
    logic [DATA_W-1:0] w_wdata;

    // Boot words are 16 bits; wider instruction words are zero-extended.
    function automatic logic [DATA_W-1:0] boot_word(input logic [ADDR_W-1:0] a);
        logic [15:0] w;
        case (a)
            ADDR_W'(0): w = 16'h7202;
            ADDR_W'(1): w = 16'h11CE;
            ADDR_W'(2): w = 16'h211D;
            ADDR_W'(3): w = 16'h4112;
            ADDR_W'(4): w = 16'hF001;
            default:    w = 16'h0000;
        endcase
        return DATA_W'(w);
    endfunction

    assign w_fetch_ok = {1'b0, fetch_addr} < DEPTH_C;
    assign w_ld_ok    = {1'b0, ld_addr} < DEPTH_C;
    assign w_fetch_go = (r_state == S_RUN) && fetch_req;
    assign w_ridx     = fetch_addr[IDX_W-1:0];

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_INIT;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_INIT:  if (r_cnt == LAST_C) w_next = S_RUN;
            S_RUN:   if (ld_start)        w_next = S_LOAD;
            S_LOAD:  if (ld_done)         w_next = S_RUN;
            default: w_next = S_INIT;
        endcase
    end

    // Single write port shared by the boot imager and the host loader.
    always_comb begin
        w_we    = 1'b0;
        w_widx  = r_cnt[IDX_W-1:0];
        w_wdata = boot_word(r_cnt);
        if (r_state == S_INIT) begin
            w_we = 1'b1;
        end else if ((r_state == S_LOAD) && ld_we && w_ld_ok) begin
            w_we    = 1'b1;
            w_widx  = ld_addr[IDX_W-1:0];
            w_wdata = ld_data;
        end
    end

    always_ff @(posedge clk) begin
        if (w_we && !rst) r_mem[w_widx] <= w_wdata;
    end

    // ready/ld_busy follow the state one cycle late, matching the handshake timing.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt    <= '0;
            r_ready  <= 1'b0;
            r_busy   <= 1'b0;
            r_fvalid <= 1'b0;
            r_ferr   <= 1'b0;
            r_lderr  <= 1'b0;
            r_finstr <= '0;
        end else begin
            r_ready  <= (r_state == S_RUN);
            r_busy   <= (r_state == S_LOAD);
            r_fvalid <= w_fetch_go;
            r_ferr   <= w_fetch_go && !w_fetch_ok;
            r_lderr  <= (r_state == S_LOAD) && ld_we && !w_ld_ok;
            if (r_state == S_INIT) r_cnt <= r_cnt + 1'b1;
            if (w_fetch_go) r_finstr <= w_fetch_ok ? r_mem[w_ridx] : '0;
        end
    end

    assign ready       = r_ready;
    assign ld_busy     = r_busy;
    assign fetch_valid = r_fvalid;
    assign fetch_err   = r_ferr;
    assign fetch_instr = r_finstr;
    assign ld_err      = r_lderr;

endmodule

// File: tb/tb_instr_mem.sv
// Bench for instr_mem: two instances (DEPTH 256 and 200) share stimulus and are
// compared every cycle against a transaction-level model, plus literal checks.
module tb_instr_mem;

    logic        clk = 1'b0;
    logic        rst;
    logic        fetch_req;
    logic [7:0]  fetch_addr;
    logic        ld_start;
    logic        ld_we;
    logic [7:0]  ld_addr;
    logic [15:0] ld_data;
    logic        ld_done;

    logic        ready_a, fvalid_a, ferr_a, busy_a, lderr_a;
    logic [15:0] instr_a;
    logic        ready_b, fvalid_b, ferr_b, busy_b, lderr_b;
    logic [15:0] instr_b;

    always #5 clk = ~clk;

    instr_mem #(.DATA_W(16), .ADDR_W(8), .DEPTH(256)) u_a (
        .clk(clk), .rst(rst), .ready(ready_a),
        .fetch_req(fetch_req), .fetch_addr(fetch_addr),
        .fetch_valid(fvalid_a), .fetch_instr(instr_a), .fetch_err(ferr_a),
        .ld_start(ld_start), .ld_we(ld_we), .ld_addr(ld_addr), .ld_data(ld_data),
        .ld_done(ld_done), .ld_busy(busy_a), .ld_err(lderr_a)
    );

    instr_mem #(.DATA_W(16), .ADDR_W(8), .DEPTH(200)) u_b (
        .clk(clk), .rst(rst), .ready(ready_b),
        .fetch_req(fetch_req), .fetch_addr(fetch_addr),
        .fetch_valid(fvalid_b), .fetch_instr(instr_b), .fetch_err(ferr_b),
        .ld_start(ld_start), .ld_we(ld_we), .ld_addr(ld_addr), .ld_data(ld_data),
        .ld_done(ld_done), .ld_busy(busy_b), .ld_err(lderr_b)
    );

    int n_tests = 0;
    int n_fail  = 0;
    bit cmp_en  = 1'b0;

    // Reference model: mode 0=imaging, 1=running, 2=loading.
    int          depth_m [2] = '{256, 200};
    int          m_mode  [2];
    int          m_cnt   [2];
    logic [15:0] m_mem   [2][256];
    logic        e_ready [2], e_busy [2], e_valid [2], e_err [2], e_lderr [2];
    logic [15:0] e_instr [2];

    function automatic logic [15:0] boot_of(input int a);
        case (a)
            0: return 16'h7202;
            1: return 16'h11CE;
            2: return 16'h211D;
            3: return 16'h4112;
            4: return 16'hF001;
            default: return 16'h0000;
        endcase
    endfunction

    task automatic model_step(input int k);
        int mode_now;
        if (rst) begin
            m_mode[k] = 0; m_cnt[k] = 0;
            e_ready[k] = 0; e_busy[k] = 0; e_valid[k] = 0;
            e_err[k] = 0; e_lderr[k] = 0; e_instr[k] = 16'h0;
        end else begin
            mode_now   = m_mode[k];
            e_ready[k] = (mode_now == 1);
            e_busy[k]  = (mode_now == 2);
            e_valid[k] = 0; e_err[k] = 0; e_lderr[k] = 0;
            if (mode_now == 0) begin
                m_mem[k][m_cnt[k]] = boot_of(m_cnt[k]);
                if (m_cnt[k] == depth_m[k] - 1) m_mode[k] = 1;
                m_cnt[k] = m_cnt[k] + 1;
            end else if (mode_now == 1) begin
                if (fetch_req) begin
                    e_valid[k] = 1;
                    e_err[k]   = (int'(fetch_addr) >= depth_m[k]);
                    e_instr[k] = e_err[k] ? 16'h0 : m_mem[k][fetch_addr];
                end
                if (ld_start) m_mode[k] = 2;
            end else begin
                if (ld_we) begin
                    if (int'(ld_addr) < depth_m[k]) m_mem[k][ld_addr] = ld_data;
                    else e_lderr[k] = 1;
                end
                if (ld_done) m_mode[k] = 1;
            end
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step(0);
        model_step(1);
    end

    initial forever begin
        @(negedge clk);
        if (cmp_en) begin
            chk("a.ready", 32'(ready_a), 32'(e_ready[0]));
            chk("a.busy",  32'(busy_a),  32'(e_busy[0]));
            chk("a.valid", 32'(fvalid_a), 32'(e_valid[0]));
            chk("a.ferr",  32'(ferr_a),  32'(e_err[0]));
            chk("a.lderr", 32'(lderr_a), 32'(e_lderr[0]));
            chk("a.instr", 32'(instr_a), 32'(e_instr[0]));
            chk("b.ready", 32'(ready_b), 32'(e_ready[1]));
            chk("b.busy",  32'(busy_b),  32'(e_busy[1]));
            chk("b.valid", 32'(fvalid_b), 32'(e_valid[1]));
            chk("b.ferr",  32'(ferr_b),  32'(e_err[1]));
            chk("b.lderr", 32'(lderr_b), 32'(e_lderr[1]));
            chk("b.instr", 32'(instr_b), 32'(e_instr[1]));
        end
    end

    task automatic idle_inputs();
        fetch_req = 0; fetch_addr = 0; ld_start = 0; ld_we = 0;
        ld_addr = 0; ld_data = 0; ld_done = 0;
    endtask

    task automatic wait_ready_a(input string name, input int limit);
        int n;
        n = -1;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (ready_a) begin n = i; break; end
        end
        if (n < 0) chk({name, ".timeout"}, 32'(ready_a), 32'd1);
    endtask

    logic [7:0] seq [5] = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd1};

    initial begin
        int na, nb;
        rst = 1'b1;
        idle_inputs();
        repeat (3) @(negedge clk);
        cmp_en = 1'b1;
        chk("rst.outs_a", {26'b0, ready_a, fvalid_a, ferr_a, busy_a, lderr_a, |instr_a}, 32'd0);
        chk("rst.outs_b", {26'b0, ready_b, fvalid_b, ferr_b, busy_b, lderr_b, |instr_b}, 32'd0);

        // Release reset; the next rising edge is cycle 0.
        rst = 1'b0;
        na = -1; nb = -1;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (ready_b && nb < 0) nb = i;
            if (ready_a) begin na = i; break; end
        end
        chk("boot.ready_cycle_a", 32'(na), 32'd256);
        chk("boot.ready_cycle_b", 32'(nb), 32'd200);

        for (int i = 0; i < 6; i++) begin
            fetch_req = 1; fetch_addr = 8'(i);
            @(negedge clk);
            fetch_req = 0;
            chk("boot.fetch_valid", 32'(fvalid_a), 32'd1);
            chk("boot.fetch_word", 32'(instr_a), 32'(boot_of(i)));
        end

        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (i > 0) begin
                chk("stream.valid", 32'(fvalid_a), 32'd1);
                chk("stream.word", 32'(instr_a), 32'(boot_of(int'(seq[i-1]))));
            end
            fetch_req = 1; fetch_addr = seq[i];
        end
        @(negedge clk);
        chk("stream.last", 32'(instr_a), 32'h11CE);
        fetch_req = 0;

        // Load window: fetch ignored while halted, written word visible afterwards.
        @(negedge clk); ld_start = 1;
        @(negedge clk); ld_start = 0; fetch_req = 1; fetch_addr = 8'd2;
        @(negedge clk);
        chk("load.fetch_blocked", 32'(fvalid_a), 32'd0);
        chk("load.busy", 32'(busy_a), 32'd1);
        chk("load.ready_low", 32'(ready_a), 32'd0);
        fetch_req = 0; ld_we = 1; ld_addr = 8'd2; ld_data = 16'h3ABC;
        @(negedge clk); ld_we = 0; ld_done = 1;
        @(negedge clk); ld_done = 0; fetch_req = 1; fetch_addr = 8'd2;
        chk("load.busy_tail", 32'(busy_a), 32'd1);
        @(negedge clk); fetch_req = 0;
        chk("load.post_valid", 32'(fvalid_a), 32'd1);
        chk("load.post_word", 32'(instr_a), 32'h3ABC);
        chk("load.busy_clear", 32'(busy_a), 32'd0);
        chk("load.ready_back", 32'(ready_a), 32'd1);

        // Fetch and ld_start together, then ld_we and ld_done together.
        @(negedge clk); fetch_req = 1; fetch_addr = 8'd0; ld_start = 1;
        @(negedge clk); fetch_req = 0; ld_start = 0;
        chk("sim.fetch_served", 32'(fvalid_a), 32'd1);
        chk("sim.fetch_word", 32'(instr_a), 32'h7202);
        @(negedge clk);
        chk("sim.busy", 32'(busy_a), 32'd1);
        ld_we = 1; ld_addr = 8'd5; ld_data = 16'hBEEF; ld_done = 1;
        @(negedge clk); ld_we = 0; ld_done = 0;
        @(negedge clk);
        @(negedge clk); fetch_req = 1; fetch_addr = 8'd5;
        @(negedge clk); fetch_req = 0;
        chk("sim.we_done_word", 32'(instr_a), 32'hBEEF);

        // Out-of-range fetch and load on the 200-word instance.
        @(negedge clk); fetch_req = 1; fetch_addr = 8'd250;
        @(negedge clk); fetch_req = 0;
        chk("oor.fetch_err_b", 32'(ferr_b), 32'd1);
        chk("oor.fetch_valid_b", 32'(fvalid_b), 32'd1);
        chk("oor.fetch_word_b", 32'(instr_b), 32'd0);
        chk("oor.fetch_err_a", 32'(ferr_a), 32'd0);
        @(negedge clk); ld_start = 1;
        @(negedge clk); ld_start = 0; ld_we = 1; ld_addr = 8'd220; ld_data = 16'h5555;
        @(negedge clk); ld_we = 0; ld_done = 1;
        chk("oor.lderr_b", 32'(lderr_b), 32'd1);
        chk("oor.lderr_a", 32'(lderr_a), 32'd0);
        @(negedge clk); ld_done = 0; fetch_req = 1; fetch_addr = 8'd20;
        chk("oor.lderr_pulse", 32'(lderr_b), 32'd0);
        @(negedge clk); fetch_addr = 8'd220;
        chk("oor.no_alias_b", 32'(instr_b), 32'd0);
        @(negedge clk); fetch_req = 0;
        chk("oor.word_a", 32'(instr_a), 32'h5555);
        chk("oor.err_b", 32'(ferr_b), 32'd1);

        // Reset in the middle of a load restarts imaging.
        @(negedge clk); ld_start = 1;
        @(negedge clk); ld_start = 0; ld_we = 1; ld_addr = 8'd0; ld_data = 16'h1234;
        @(negedge clk); ld_we = 0; rst = 1;
        chk("rstload.busy_before", 32'(busy_a), 32'd1);
        @(negedge clk); rst = 0;
        chk("rstload.busy", 32'(busy_a), 32'd0);
        chk("rstload.ready", 32'(ready_a), 32'd0);
        wait_ready_a("rstload", 300);
        fetch_req = 1; fetch_addr = 8'd0;
        @(negedge clk); fetch_req = 0;
        chk("rstload.word0", 32'(instr_a), 32'h7202);

        // Random traffic, including commands outside their legal states.
        for (int i = 0; i < 800; i++) begin
            @(negedge clk);
            fetch_req  = 1'($urandom_range(0, 1));
            fetch_addr = 8'($urandom_range(0, 255));
            ld_start   = ($urandom_range(0, 15) == 0);
            ld_we      = ($urandom_range(0, 2) == 0);
            ld_addr    = 8'($urandom_range(0, 255));
            ld_data    = 16'($urandom);
            ld_done    = ($urandom_range(0, 7) == 0);
        end
        @(negedge clk); idle_inputs();
        repeat (3) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
